mac_bus_ctrl: RTL and testbench
===============================

Name: mac_bus_ctrl

Overview:
- Sits directly downstream of the 68000-compatible CPU bus wrapper. Consumes its AS/UDS/LDS/RW/FC/address strobes and the VMA/E timing outputs.
- Produces DTACK, VPA and BERR back to the CPU.
- Decodes the Mac Plus 24-bit map into RAM/ROM memory requests, with a req/ack handshake to the SDRAM arbiter, plus VIA/SCC/IWM selects.
- Owns the boot ROM overlay flag and a bus-error watchdog.

Parameters:
- TIMEOUT, 1023, clk cycles with AS asserted and no termination before BERR is raised.
- RAM_AW, 22, RAM byte-address width; RAM is mirrored across $000000-$3FFFFF.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- as_n  in  1  CPU address strobe
- uds_n  in  1  upper data strobe
- lds_n  in  1  lower data strobe
- rw_n  in  1  1=read, 0=write
- fc  in  3  CPU function code
- addr  in  24  CPU byte address; bit 0 ignored
- vma_n  in  1  valid memory address from the wrapper's E-clock logic
- e_negclken  in  1  one-clk pulse at the E falling edge
- dtack_n  out  1  data acknowledge to CPU
- vpa_n  out  1  valid peripheral address / autovector request to CPU
- berr  out  1  bus error to CPU
- mem_req  out  1  one-clk request pulse to the SDRAM arbiter
- mem_ack  in  1  one-clk completion pulse from the arbiter
- mem_rom  out  1  1=ROM space, 0=RAM space; valid while the request is pending
- mem_we  out  1  write enable, equal to ~rw_n latched at request time
- mem_be  out  2  byte enables {~uds_n,~lds_n} latched at request time
- mem_addr  out  RAM_AW  byte address for the arbiter
- via_cs  out  1  VIA select
- scc_cs  out  1  SCC select
- iwm_cs  out  1  IWM select
- overlay  out  1  ROM overlay flag

Behaviour:
- Reset values:
  - dtack_n=1, vpa_n=1, berr=0
  - mem_req=0, all *_cs=0, mem_we=0, mem_be=0, mem_addr=0, mem_rom=0
  - overlay=1, state=IDLE, watchdog=0
- Decode uses addr[23:20], evaluated on the cycle the transaction is accepted:
  - 0-3: RAM. When overlay=1 this range maps to ROM instead.
  - 4-5: ROM. Any access here clears overlay on acceptance; it stays clear until reset.
  - 9 or B: SCC.
  - D: IWM.
  - E: VIA.
  - fc==3'b111: interrupt acknowledge. This overrides the address decode.
  - Anything else: unmapped; no termination is ever given.
- Peripheral addresses are mem_addr-independent. ROM mem_addr = addr[RAM_AW-1:0] with the top bits masked by the arbiter.
- FSM, sampled every clk:
  - IDLE:
    - Accept when as_n=0 and (rw_n=1 or uds_n&lds_n==0). Writes wait for their data strobes, which arrive later than AS.
    - RAM/ROM: pulse mem_req, latch mem_we/mem_be/mem_addr/mem_rom, go to MEMW.
    - SCC/IWM: assert the matching *_cs and assert dtack_n=0 the next cycle, go to HOLD.
    - VIA or IACK: vpa_n=0, go to PERW.
    - Unmapped: go to HOLD with no termination.
  - MEMW: on mem_ack, dtack_n=0 on the next cycle, go to HOLD.
    - If mem_ack and as_n rise arrive in the same cycle, honour the ack but drop dtack immediately. No stale DTACK is allowed.
  - PERW: when vma_n=0, assert via_cs (not for IACK). On the following e_negclken, go to HOLD. vpa_n stays asserted.
  - HOLD: hold all terminations until as_n=1. Then dtack_n=1, vpa_n=1, all *_cs=0, go to IDLE on the same cycle.
- Watchdog:
  - Counts while as_n=0 and state!=IDLE, and also while the IDLE write-wait is pending.
  - On reaching TIMEOUT: berr=1 and the FSM is forced to HOLD.
  - berr clears when as_n=1. The counter clears whenever as_n=1.
- as_n rising in any state except HOLD aborts to IDLE and clears outputs.
  - An outstanding mem_ack arriving later is ignored. Track this with a 1-bit pending flag that swallows exactly one ack.
- Back-to-back cycles: IDLE is re-entered on the as_n rising edge, so a new AS falling edge is accepted on any later cycle. Minimum one cycle with as_n=1 between cycles.
- The same IDLE path serves wrapper re-runs during bus-grant stalls: as_n stays high and the FSM stays in IDLE.
- Reset mid-transaction: all outputs return to their reset values in the next cycle, overlay=1, and the pending flag is cleared.

Decomposition:
- Package mac_bus_pkg holds:
  - region enum {REG_RAM, REG_ROM, REG_SCC, REG_IWM, REG_VIA, REG_IACK, REG_NONE}
  - state enum {IDLE, MEMW, PERW, HOLD}
  - address nibble constants
- Sub-module mac_addr_decode: purely combinational, (addr[23:20], fc, overlay) -> region. Everything else stays in the top module.

Test Plan:
- Reset release; read $000010 with overlay=1 -> mem_req with mem_rom=1. Then read $400000 -> overlay=0. Re-read $000010 -> mem_rom=0, mem_addr=$000010.
- Word write $001234, as_n low 2 cycles before uds/lds go low -> mem_req only after the strobes; mem_we=1, mem_be=2'b11. Ack after 5 cycles -> dtack_n low 1 cycle later, high the cycle after as_n rises.
- Read $EFE1FE -> vpa_n=0 and via_cs asserted only after vma_n=0; HOLD entered on e_negclken; all outputs released when as_n=1. dtack_n stays 1 throughout.
- IACK with fc=7, addr=$FFFFF5 -> vpa_n=0, no *_cs, no mem_req.
- Read $F00000 (unmapped) held 1023 cycles -> berr=1 exactly at TIMEOUT, cleared when as_n rises. Next RAM read works normally.
- as_n rises in MEMW before mem_ack; ack arrives 3 cycles later and a new read starts -> the stale ack is swallowed, the new read gets its own ack, and dtack_n is never asserted early.

Source files
------------

// File: rtl/mac_bus_pkg.sv
// Shared types and address-map constants for the Mac Plus bus controller.
package mac_bus_pkg;

    // Decoded target of a CPU bus cycle
    typedef enum logic [2:0] {
        REG_RAM,
        REG_ROM,
        REG_SCC,
        REG_IWM,
        REG_VIA,
        REG_IACK,
        REG_NONE
    } region_t;

    // Bus-cycle controller states
    typedef enum logic [1:0] {
        IDLE,
        MEMW,
        PERW,
        HOLD
    } state_t;

    // addr[23:20] nibbles of the 24-bit map
    localparam logic [3:0] NIB_RAM_MAX = 4'h3;
    localparam logic [3:0] NIB_ROM0    = 4'h4;
    localparam logic [3:0] NIB_ROM1    = 4'h5;
    localparam logic [3:0] NIB_SCC0    = 4'h9;
    localparam logic [3:0] NIB_SCC1    = 4'hB;
    localparam logic [3:0] NIB_IWM     = 4'hD;
    localparam logic [3:0] NIB_VIA     = 4'hE;

    // Function code of an interrupt-acknowledge cycle
    localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/mac_addr_decode.sv
// Combinational address decode: top address nibble, function code and the
// boot overlay flag select the target region. IACK overrides the map.
module mac_addr_decode
    import mac_bus_pkg::*;
(
    input  logic [3:0] nib,
    input  logic [2:0] fc,
    input  logic       overlay,
    output region_t    region
);

    // Region select; RAM space reads as ROM while the overlay is set
    always_comb begin
        region = REG_NONE;
        if (fc == FC_IACK) begin
            region = REG_IACK;
        end else if (nib <= NIB_RAM_MAX) begin
            region = overlay ? REG_ROM : REG_RAM;
        end else begin
            case (nib)
                NIB_ROM0, NIB_ROM1: region = REG_ROM;
                NIB_SCC0, NIB_SCC1: region = REG_SCC;
                NIB_IWM:            region = REG_IWM;
                NIB_VIA:            region = REG_VIA;
                default:            region = REG_NONE;
            endcase
        end
    end

endmodule

// File: rtl/mac_bus_ctrl.sv
// Mac Plus bus controller: terminates 68000 bus cycles (DTACK/VPA/BERR),
// issues RAM/ROM requests to the SDRAM arbiter, drives peripheral selects,
// and owns the boot overlay flag and the bus-error watchdog.
module mac_bus_ctrl
    import mac_bus_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int RAM_AW  = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_n,
    input  logic              uds_n,
    input  logic              lds_n,
    input  logic              rw_n,
    input  logic [2:0]        fc,
    input  logic [23:0]       addr,
    input  logic              vma_n,
    input  logic              e_negclken,
    output logic              dtack_n,
    output logic              vpa_n,
    output logic              berr,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_rom,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [RAM_AW-1:0] mem_addr,
    output logic              via_cs,
    output logic              scc_cs,
    output logic              iwm_cs,
    output logic              overlay
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t            state, state_nxt;
    region_t           region;
    logic [WD_W-1:0]   wd, wd_nxt, wd_inc;
    logic              pending, pending_nxt;
    logic              vma_seen, vma_seen_nxt;
    logic              is_via, is_via_nxt;
    logic              dtack_n_nxt, vpa_n_nxt, berr_nxt, mem_req_nxt;
    logic              mem_rom_nxt, mem_we_nxt;
    logic [1:0]        mem_be_nxt;
    logic [RAM_AW-1:0] mem_addr_nxt;
    logic              via_cs_nxt, scc_cs_nxt, iwm_cs_nxt, overlay_nxt;
    logic              accept, count_en, timeout, real_ack;
    logic              unused_addr0;

    assign unused_addr0 = addr[0];

    mac_addr_decode u_decode (
        .nib     (addr[23:20]),
        .fc      (fc),
        .overlay (overlay),
        .region  (region)
    );

    // Next-state and registered-output logic for the bus-cycle FSM
    always_comb begin
        state_nxt    = state;
        wd_nxt       = wd;
        pending_nxt  = pending;
        vma_seen_nxt = vma_seen;
        is_via_nxt   = is_via;
        dtack_n_nxt  = dtack_n;
        vpa_n_nxt    = vpa_n;
        berr_nxt     = berr;
        mem_req_nxt  = 1'b0;
        mem_rom_nxt  = mem_rom;
        mem_we_nxt   = mem_we;
        mem_be_nxt   = mem_be;
        mem_addr_nxt = mem_addr;
        via_cs_nxt   = via_cs;
        scc_cs_nxt   = scc_cs;
        iwm_cs_nxt   = iwm_cs;
        overlay_nxt  = overlay;

        // Writes are accepted only once a data strobe is down
        accept   = !as_n && (rw_n || !(uds_n && lds_n));
        // Counting covers the IDLE write-wait as well as every non-IDLE state
        count_en = !as_n && !(state == IDLE && accept);
        wd_inc   = wd + 1'b1;
        timeout  = count_en && !berr && (wd_inc == WD_MAX);

        // A pending flag marks an ack still owed to an aborted request
        real_ack = mem_ack && !pending;
        if (mem_ack && pending) begin
            pending_nxt = 1'b0;
        end

        if (as_n) begin
            wd_nxt = '0;
        end else if (count_en && !berr) begin
            wd_nxt = wd_inc;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    vma_seen_nxt = 1'b0;
                    is_via_nxt   = 1'b0;
                    if (region == REG_ROM &&
                        (addr[23:20] == NIB_ROM0 || addr[23:20] == NIB_ROM1)) begin
                        overlay_nxt = 1'b0;
                    end
                    case (region)
                        REG_RAM, REG_ROM: begin
                            mem_req_nxt  = 1'b1;
                            mem_rom_nxt  = (region == REG_ROM);
                            mem_we_nxt   = ~rw_n;
                            mem_be_nxt   = {~uds_n, ~lds_n};
                            mem_addr_nxt = {addr[RAM_AW-1:1], 1'b0};
                            state_nxt    = MEMW;
                        end
                        REG_SCC: begin
                            scc_cs_nxt  = 1'b1;
                            dtack_n_nxt = 1'b0;
                            state_nxt   = HOLD;
                        end
                        REG_IWM: begin
                            iwm_cs_nxt  = 1'b1;
                            dtack_n_nxt = 1'b0;
                            state_nxt   = HOLD;
                        end
                        REG_VIA: begin
                            vpa_n_nxt  = 1'b0;
                            is_via_nxt = 1'b1;
                            state_nxt  = PERW;
                        end
                        REG_IACK: begin
                            vpa_n_nxt = 1'b0;
                            state_nxt = PERW;
                        end
                        default: state_nxt = HOLD;
                    endcase
                end
            end
            MEMW: begin
                if (as_n) begin
                    // Ack in the same cycle as the abort is consumed here
                    if (!real_ack) begin
                        pending_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (real_ack) begin
                    dtack_n_nxt = 1'b0;
                    state_nxt   = HOLD;
                end
            end
            PERW: begin
                if (as_n) begin
                    state_nxt = IDLE;
                end else begin
                    if (!vma_n) begin
                        vma_seen_nxt = 1'b1;
                        via_cs_nxt   = is_via;
                    end
                    if (vma_seen && e_negclken) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (as_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobe release ends every cycle and drops every termination
        if (as_n) begin
            dtack_n_nxt  = 1'b1;
            vpa_n_nxt    = 1'b1;
            berr_nxt     = 1'b0;
            via_cs_nxt   = 1'b0;
            scc_cs_nxt   = 1'b0;
            iwm_cs_nxt   = 1'b0;
            vma_seen_nxt = 1'b0;
        end else if (timeout) begin
            berr_nxt  = 1'b1;
            state_nxt = HOLD;
        end
    end

    // State, watchdog and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wd       <= '0;
            pending  <= 1'b0;
            vma_seen <= 1'b0;
            is_via   <= 1'b0;
            dtack_n  <= 1'b1;
            vpa_n    <= 1'b1;
            berr     <= 1'b0;
            mem_req  <= 1'b0;
            mem_rom  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 2'b00;
            mem_addr <= '0;
            via_cs   <= 1'b0;
            scc_cs   <= 1'b0;
            iwm_cs   <= 1'b0;
            overlay  <= 1'b1;
        end else begin
            state    <= state_nxt;
            wd       <= wd_nxt;
            pending  <= pending_nxt;
            vma_seen <= vma_seen_nxt;
            is_via   <= is_via_nxt;
            dtack_n  <= dtack_n_nxt;
            vpa_n    <= vpa_n_nxt;
            berr     <= berr_nxt;
            mem_req  <= mem_req_nxt;
            mem_rom  <= mem_rom_nxt;
            mem_we   <= mem_we_nxt;
            mem_be   <= mem_be_nxt;
            mem_addr <= mem_addr_nxt;
            via_cs   <= via_cs_nxt;
            scc_cs   <= scc_cs_nxt;
            iwm_cs   <= iwm_cs_nxt;
            overlay  <= overlay_nxt;
        end
    end

endmodule

// File: tb/tb_mac_bus_ctrl.sv
// Directed bench for mac_bus_ctrl: overlay, memory handshake, peripherals,
// IACK, watchdog, aborts with stale acks and mid-transaction reset.
module tb_mac_bus_ctrl;
    import mac_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw_n = 1'b1;
    logic [2:0]  fc = 3'b101;
    logic [23:0] addr = 24'h0;
    logic        vma_n = 1'b1, e_negclken = 1'b0, mem_ack = 1'b0;
    logic        dtack_n, vpa_n, berr, mem_req, mem_rom, mem_we;
    logic [1:0]  mem_be;
    logic [21:0] mem_addr;
    logic        via_cs, scc_cs, iwm_cs, overlay;

    int n_cmp = 0;
    int n_err = 0;

    mac_bus_ctrl #(.TIMEOUT(1023), .RAM_AW(22)) dut (
        .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
        .rw_n(rw_n), .fc(fc), .addr(addr), .vma_n(vma_n), .e_negclken(e_negclken),
        .dtack_n(dtack_n), .vpa_n(vpa_n), .berr(berr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rom(mem_rom), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .via_cs(via_cs), .scc_cs(scc_cs), .iwm_cs(iwm_cs),
        .overlay(overlay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
        vma_n = 1'b1; e_negclken = 1'b0; mem_ack = 1'b0; fc = 3'b101;
    endtask

    // Full word read through the arbiter with an ack one cycle after the request
    task automatic mem_read(input string tag, input logic [23:0] a,
                            input logic exp_rom, input logic [21:0] exp_addr);
        addr = a; rw_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_rom"}, 32'(mem_rom), 32'(exp_rom));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd3);
        step();
        chk({tag, "_req_pulse"}, 32'(mem_req), 32'd0);
        chk({tag, "_dtack_wait"}, 32'(dtack_n), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk({tag, "_dtack"}, 32'(dtack_n), 32'd0);
        release_bus();
        step();
        chk({tag, "_dtack_rel"}, 32'(dtack_n), 32'd1);
    endtask

    initial begin
        // Reset
        release_bus();
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_dtack", 32'(dtack_n), 32'd1);
        chk("rst_vpa", 32'(vpa_n), 32'd1);
        chk("rst_berr", 32'(berr), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_cs", 32'({via_cs, scc_cs, iwm_cs}), 32'd0);
        chk("rst_mem", 32'({mem_we, mem_be, mem_rom, mem_addr}), 32'd0);
        chk("rst_overlay", 32'(overlay), 32'd1);

        // Overlay: low RAM reads ROM, then a ROM access clears the overlay
        mem_read("ovl_rd", 24'h000010, 1'b1, 22'h000010);
        chk("ovl_still_set", 32'(overlay), 32'd1);
        mem_read("rom_rd", 24'h400000, 1'b1, 22'h000000);
        chk("ovl_cleared", 32'(overlay), 32'd0);
        mem_read("ram_rd", 24'h000010, 1'b0, 22'h000010);

        // Word write: data strobes trail AS by two cycles
        addr = 24'h001234; rw_n = 1'b0; as_n = 1'b0;
        step();
        chk("wr_wait1", 32'(mem_req), 32'd0);
        step();
        chk("wr_wait2", 32'(mem_req), 32'd0);
        uds_n = 1'b0; lds_n = 1'b0;
        step();
        chk("wr_req", 32'(mem_req), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_be", 32'(mem_be), 32'd3);
        chk("wr_addr", 32'(mem_addr), 32'h1234);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wr_dtack_wait", 32'(dtack_n), 32'd1);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("wr_dtack", 32'(dtack_n), 32'd0);
        step();
        chk("wr_dtack_hold", 32'(dtack_n), 32'd0);
        release_bus();
        step();
        chk("wr_dtack_rel", 32'(dtack_n), 32'd1);

        // SCC and IWM: select plus DTACK one cycle after acceptance
        addr = 24'h9FFFF8; uds_n = 1'b0; as_n = 1'b0;
        step();
        chk("scc_cs", 32'({scc_cs, iwm_cs, via_cs}), 32'b100);
        chk("scc_dtack", 32'(dtack_n), 32'd0);
        chk("scc_noreq", 32'(mem_req), 32'd0);
        release_bus();
        step();
        chk("scc_rel", 32'({scc_cs, dtack_n}), 32'b01);
        addr = 24'hDFE1FE; lds_n = 1'b0; as_n = 1'b0;
        step();
        chk("iwm_cs", 32'({scc_cs, iwm_cs, via_cs}), 32'b010);
        chk("iwm_dtack", 32'(dtack_n), 32'd0);
        release_bus();
        step();
        chk("iwm_rel", 32'({iwm_cs, dtack_n}), 32'b01);

        // VIA: VPA at once, select after VMA, HOLD on the next E falling edge
        addr = 24'hEFE1FE; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        chk("via_vpa", 32'(vpa_n), 32'd0);
        chk("via_cs_early", 32'(via_cs), 32'd0);
        e_negclken = 1'b1;
        step();
        e_negclken = 1'b0;
        chk("via_e_before_vma", 32'(dut.state), 32'(PERW));
        vma_n = 1'b0;
        step();
        chk("via_cs", 32'(via_cs), 32'd1);
        step();
        e_negclken = 1'b1;
        step();
        e_negclken = 1'b0;
        chk("via_hold", 32'(dut.state), 32'(HOLD));
        chk("via_vpa_hold", 32'(vpa_n), 32'd0);
        chk("via_no_dtack", 32'(dtack_n), 32'd1);
        release_bus();
        step();
        chk("via_rel", 32'({vpa_n, via_cs, dtack_n}), 32'b101);

        // Interrupt acknowledge overrides the map
        fc = 3'b111; addr = 24'hFFFFF5; lds_n = 1'b0; as_n = 1'b0;
        step();
        chk("iack_vpa", 32'(vpa_n), 32'd0);
        chk("iack_noreq", 32'(mem_req), 32'd0);
        vma_n = 1'b0;
        step();
        chk("iack_no_cs", 32'({via_cs, scc_cs, iwm_cs}), 32'd0);
        e_negclken = 1'b1;
        step();
        e_negclken = 1'b0;
        chk("iack_hold", 32'(dut.state), 32'(HOLD));
        release_bus();
        step();
        chk("iack_rel", 32'(vpa_n), 32'd1);

        // Unmapped read: watchdog raises BERR exactly at TIMEOUT
        addr = 24'hF00000; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        for (int i = 0; i < 1022; i++) step();
        chk("wd_before", 32'(berr), 32'd0);
        step();
        chk("wd_berr", 32'(berr), 32'd1);
        chk("wd_no_term", 32'({dtack_n, vpa_n}), 32'b11);
        release_bus();
        step();
        chk("wd_berr_rel", 32'(berr), 32'd0);
        mem_read("post_wd", 24'h000100, 1'b0, 22'h000100);

        // Abort in MEMW; the stale ack must be swallowed
        addr = 24'h000200; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        step();
        release_bus();
        step();
        chk("abort_dtack", 32'(dtack_n), 32'd1);
        addr = 24'h000400; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        chk("abort_new_req", 32'(mem_req), 32'd1);
        chk("abort_new_addr", 32'(mem_addr), 32'h400);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stale_ack_swallowed", 32'(dtack_n), 32'd1);
        step();
        chk("stale_ack_late1", 32'(dtack_n), 32'd1);
        step();
        chk("stale_ack_late2", 32'(dtack_n), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("own_ack_dtack", 32'(dtack_n), 32'd0);
        release_bus();
        step();
        chk("own_ack_rel", 32'(dtack_n), 32'd1);

        // Ack coinciding with AS release: no DTACK and nothing left pending
        addr = 24'h000600; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        step();
        release_bus();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("ack_as_rise_dtack", 32'(dtack_n), 32'd1);
        mem_read("after_coincide", 24'h000800, 1'b0, 22'h000800);

        // Reset mid-transaction with an outstanding ack owed
        addr = 24'h000A00; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        step();
        step();
        release_bus();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_overlay", 32'(overlay), 32'd1);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_req", 32'(mem_req), 32'd0);
        step();
        mem_read("mrst_rd", 24'h000010, 1'b1, 22'h000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
